factor_fetch_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single factor-matrix memory read port among all MTTKRP compute units. It collects per-unit factor-row address requests, issues one at a time to memory with the unit's compute ID, and routes the returned factor rows back to the requesting unit. It sits between the compute-unit array and the factor-matrix memory controller, replacing the fixed lowest-index priority mux on the address path.

---
 rtl/mttkrp_pkg.sv | 27 ++
 rtl/rr_priority_picker.sv | 41 ++++
 rtl/factor_fetch_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_factor_fetch_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mttkrp_pkg.sv
// Shared definitions for the MTTKRP factor-fetch path: the fetch FSM state
// encoding and helpers that size compute-unit IDs and round-robin pointers.
package mttkrp_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_ISSUE = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_RESP  = 2'd3
    } fetch_state_t;

    // IDs carry one extra bit so the value N ("no unit") is representable.
    function automatic int fetch_id_width(input int num_units);
        return $clog2(num_units) + 1;
    endfunction

    // Width of a plain unit index / round-robin pointer (0 .. N-1).
    function automatic int fetch_ptr_width(input int num_units);
        return (num_units > 1) ? $clog2(num_units) : 1;
    endfunction

    // ID reported on the memory and response sides when no unit is being served.
    function automatic int no_unit_id(input int num_units);
        return num_units;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first requesting unit at or
// above ptr, wrapping from N-1 back to 0, plus a flag when any unit requests.
module rr_priority_picker
    import mttkrp_pkg::*;
#(
    parameter int NUM_COMPUTE_UNITS = 320,
    parameter int PTR_WIDTH         = fetch_ptr_width(NUM_COMPUTE_UNITS)
) (
    input  logic [NUM_COMPUTE_UNITS-1:0] req,
    input  logic [PTR_WIDTH-1:0]         ptr,
    output logic [PTR_WIDTH-1:0]         winner,
    output logic                         found
);

    logic [NUM_COMPUTE_UNITS-1:0] upper_mask;
    logic [NUM_COMPUTE_UNITS-1:0] upper_req;
    logic [NUM_COMPUTE_UNITS-1:0] search_vec;

    // Units at or above the pointer get first chance; the rest are the wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COMPUTE_UNITS; gi++) begin : g_mask
            assign upper_mask[gi] = (PTR_WIDTH'(gi) >= ptr);
        end
    endgenerate

    assign upper_req  = req & upper_mask;
    assign search_vec = (|upper_req) ? upper_req : req;
    assign found      = |req;

    // Lowest set bit of the selected half; the descending scan lets the lowest index win.
    always_comb begin
        winner = '0;
        for (int i = NUM_COMPUTE_UNITS - 1; i >= 0; i--) begin
            if (search_vec[i]) begin
                winner = PTR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/factor_fetch_arbiter.sv
// Round-robin arbiter and sequencer sharing the single factor-matrix memory
// read port among all compute units. One request is outstanding at a time:
// pick a unit, present its factor-row addresses, wait for the rows, and
// strobe them back tagged with the unit's ID.
// Optional watchdog: define FACTOR_ARB_TIMEOUT_EN to abandon a WAIT that
// lasts TIMEOUT_CYCLES cycles and raise the sticky timeout_err flag.
module factor_fetch_arbiter
    import mttkrp_pkg::*;
#(
    parameter int NUM_COMPUTE_UNITS      = 320,
    parameter int TENSOR_DIMENSIONS      = 3,
    parameter int MODE_TENSOR_ADDR_WIDTH = 16,
    parameter int RANK_FACTOR_MATRIX     = 16,
    parameter int FACTOR_MATRIX_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES         = 1024
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_COMPUTE_UNITS-1:0]                          req_en,
    input  logic [NUM_COMPUTE_UNITS*(TENSOR_DIMENSIONS-1)*MODE_TENSOR_ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_COMPUTE_UNITS-1:0]                          grant,
    output logic                                                  mem_addr_en,
    output logic [(TENSOR_DIMENSIONS-1)*MODE_TENSOR_ADDR_WIDTH-1:0] mem_addr,
    output logic [$clog2(NUM_COMPUTE_UNITS):0]                    mem_compute_id,
    input  logic                                                  mem_addr_ready,
    input  logic                                                  mem_data_en,
    input  logic [(TENSOR_DIMENSIONS-1)*RANK_FACTOR_MATRIX*FACTOR_MATRIX_WIDTH-1:0] mem_data,
    output logic                                                  resp_en,
    output logic [$clog2(NUM_COMPUTE_UNITS):0]                    resp_compute_id,
    output logic [(TENSOR_DIMENSIONS-1)*RANK_FACTOR_MATRIX*FACTOR_MATRIX_WIDTH-1:0] resp_data,
    output logic                                                  busy,
    output logic                                                  timeout_err
);

    localparam int N  = NUM_COMPUTE_UNITS;
    localparam int AW = (TENSOR_DIMENSIONS - 1) * MODE_TENSOR_ADDR_WIDTH;
    localparam int DW = (TENSOR_DIMENSIONS - 1) * RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH;
    localparam int IW = fetch_id_width(N);
    localparam int PW = fetch_ptr_width(N);
    localparam logic [IW-1:0] NO_UNIT  = IW'(no_unit_id(N));
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

    fetch_state_t       state_reg, state_next;
    logic [PW-1:0]      ptr_reg;
    logic [IW-1:0]      id_reg;
    logic [AW-1:0]      addr_reg;
    logic [N-1:0]       grant_reg;
    logic [DW-1:0]      resp_data_reg;
    logic [PW-1:0]      winner_idx;
    logic               winner_found;
    logic               accept_req;
    logic               capture_data;
    logic               timeout_hit;
    logic [AW-1:0]      unit_addr [N];

    // Split the flat address bus into one entry per unit for the winner mux.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unit_addr
            assign unit_addr[gi] = req_addr[gi*AW +: AW];
        end
    endgenerate

    rr_priority_picker #(
        .NUM_COMPUTE_UNITS (N),
        .PTR_WIDTH         (PW)
    ) u_picker (
        .req    (req_en),
        .ptr    (ptr_reg),
        .winner (winner_idx),
        .found  (winner_found)
    );

    // Requests are only looked at in IDLE; data is only taken in WAIT.
    assign accept_req   = (state_reg == FETCH_IDLE) && winner_found;
    assign capture_data = (state_reg == FETCH_WAIT) && mem_data_en;

`ifdef FACTOR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_reg;
    logic          timeout_err_reg;

    // Fires on the last allowed WAIT cycle when the memory still has not answered.
    assign timeout_hit = (state_reg == FETCH_WAIT) && !mem_data_en &&
                         (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog: count WAIT cycles from zero on every entry; the error flag is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == FETCH_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    // Watchdog not built: WAIT lasts until data arrives. The comparison is never
    // true for a legal (positive) limit and keeps the parameter referenced.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the single-outstanding fetch sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH_IDLE:  if (winner_found)   state_next = FETCH_ISSUE;
            FETCH_ISSUE: if (mem_addr_ready) state_next = FETCH_WAIT;
            FETCH_WAIT: begin
                if (mem_data_en) begin
                    state_next = FETCH_RESP;
                end else if (timeout_hit) begin
                    state_next = FETCH_IDLE;
                end
            end
            FETCH_RESP:  state_next = FETCH_IDLE;
            default:     state_next = FETCH_IDLE;
        endcase
    end

    // Datapath: latch the winner's address/ID, advance the pointer past it,
    // pulse its grant for one cycle, and hold a copy of the returned rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            id_reg        <= NO_UNIT;
            addr_reg      <= '0;
            grant_reg     <= '0;
            resp_data_reg <= '0;
        end else begin
            grant_reg <= '0;
            if (accept_req) begin
                grant_reg <= {{(N-1){1'b0}}, 1'b1} << winner_idx;
                addr_reg  <= unit_addr[winner_idx];
                id_reg    <= IW'(winner_idx);
                ptr_reg   <= (winner_idx == LAST_IDX) ? '0 : winner_idx + 1'b1;
            end
            if (capture_data) begin
                resp_data_reg <= mem_data;
            end
        end
    end

    // Outputs decoded from the current state; IDs read as N whenever nobody is served.
    always_comb begin
        mem_addr_en     = 1'b0;
        resp_en         = 1'b0;
        busy            = 1'b0;
        mem_compute_id  = NO_UNIT;
        resp_compute_id = NO_UNIT;
        if (state_reg != FETCH_IDLE) begin
            busy           = 1'b1;
            mem_compute_id = id_reg;
        end
        if (state_reg == FETCH_ISSUE) begin
            mem_addr_en = 1'b1;
        end
        if (state_reg == FETCH_RESP) begin
            resp_en         = 1'b1;
            resp_compute_id = id_reg;
        end
    end

    assign grant     = grant_reg;
    assign mem_addr  = addr_reg;
    assign resp_data = resp_data_reg;

endmodule

// File: tb/tb_factor_fetch_arbiter.sv
// Self-checking bench for factor_fetch_arbiter (N=8). Background processes
// model the requesting units and the memory; monitors pop expected grants and
// responses from scoreboard queues filled by the scenario tasks.
module tb_factor_fetch_arbiter;

    localparam int N  = 8;
    localparam int D  = 3;
    localparam int A  = 16;
    localparam int R  = 2;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int IW = $clog2(N) + 1;
    localparam int AW = (D - 1) * A;
    localparam int DW = (D - 1) * R * W;
    localparam logic [IW-1:0] NO_ID = IW'(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_en = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      grant;
    logic              mem_addr_en;
    logic [AW-1:0]     mem_addr;
    logic [IW-1:0]     mem_compute_id;
    logic              mem_addr_ready = 1'b0;
    logic              mem_data_en = 1'b0;
    logic [DW-1:0]     mem_data = '0;
    logic              resp_en;
    logic [IW-1:0]     resp_compute_id;
    logic [DW-1:0]     resp_data;
    logic              busy;
    logic              timeout_err;

    always #5 clk = ~clk;

    factor_fetch_arbiter #(
        .NUM_COMPUTE_UNITS      (N),
        .TENSOR_DIMENSIONS      (D),
        .MODE_TENSOR_ADDR_WIDTH (A),
        .RANK_FACTOR_MATRIX     (R),
        .FACTOR_MATRIX_WIDTH    (W),
        .TIMEOUT_CYCLES         (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_en          (req_en),
        .req_addr        (req_addr),
        .grant           (grant),
        .mem_addr_en     (mem_addr_en),
        .mem_addr        (mem_addr),
        .mem_compute_id  (mem_compute_id),
        .mem_addr_ready  (mem_addr_ready),
        .mem_data_en     (mem_data_en),
        .mem_data        (mem_data),
        .resp_en         (resp_en),
        .resp_compute_id (resp_compute_id),
        .resp_data       (resp_data),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    int vec_count = 0;
    int err_count = 0;

    logic [AW-1:0]    unit_addr [N];
    int               gq [$];
    logic [IW+DW-1:0] rq [$];

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [IW+DW-1:0] exp_resp(input int k);
        return {IW'(k), mem_model(unit_addr[k])};
    endfunction

    // Requesting units: hold req_en until granted, re-raise after the response.
    int remaining   [N];
    bit outstanding [N];
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                outstanding[k] = 1'b0;
                remaining[k]   = 0;
            end else begin
                if (grant[k]) begin
                    outstanding[k] = 1'b1;
                    remaining[k]   = remaining[k] - 1;
                end
                if (resp_en && resp_compute_id == IW'(k)) outstanding[k] = 1'b0;
            end
            req_en[k] = !rst && (remaining[k] > 0) && !outstanding[k];
        end
    end

    // Memory model: ready after ready_delay ISSUE cycles, data the cycle after.
    int            ready_delay = 0;
    bit            spurious    = 1'b0;
    bit            hold_data   = 1'b0;
    int            rdy_cnt     = 0;
    bit            pend        = 1'b0;
    logic [DW-1:0] pend_data   = '0;
    always @(negedge clk) begin
        mem_addr_ready = 1'b0;
        mem_data_en    = 1'b0;
        mem_data       = '0;
        if (rst) begin
            rdy_cnt = 0;
        end else if (mem_addr_en) begin
            if (spurious) begin
                mem_data_en = 1'b1;
                mem_data    = 32'hDEADBEEF;
            end
            if (rdy_cnt >= ready_delay) begin
                mem_addr_ready = 1'b1;
                pend           = 1'b1;
                pend_data      = mem_model(mem_addr);
                rdy_cnt        = 0;
            end else begin
                rdy_cnt++;
            end
        end else if (pend && !hold_data) begin
            mem_data_en = 1'b1;
            mem_data    = pend_data;
            pend        = 1'b0;
        end
    end

    // Grant and response monitors against the scoreboard queues.
    int               mon_unit;
    logic [N-1:0]     mon_onehot;
    logic [IW+DW-1:0] mon_resp;
    always @(negedge clk) begin
        if (!rst && grant != '0) begin
            vec_count++;
            if (gq.size() == 0) begin
                err_count++;
                $display("FAIL grant_unexpected: got grant=%b, required no grant", grant);
            end else begin
                mon_unit = gq.pop_front();
                mon_onehot = '0;
                mon_onehot[mon_unit] = 1'b1;
                if (grant !== mon_onehot || mem_compute_id !== IW'(mon_unit) ||
                    mem_addr !== unit_addr[mon_unit] || mem_addr_en !== 1'b1) begin
                    err_count++;
                    $display("FAIL grant: got grant=%b id=%0d addr=%h en=%b, required grant=%b id=%0d addr=%h en=1",
                             grant, mem_compute_id, mem_addr, mem_addr_en, mon_onehot, mon_unit, unit_addr[mon_unit]);
                end
            end
        end
        if (!rst && resp_en) begin
            vec_count++;
            if (rq.size() == 0) begin
                err_count++;
                $display("FAIL resp_unexpected: got resp id=%0d data=%h, required no response", resp_compute_id, resp_data);
            end else begin
                mon_resp = rq.pop_front();
                if ({resp_compute_id, resp_data} !== mon_resp) begin
                    err_count++;
                    $display("FAIL resp: got id=%0d data=%h, required id=%0d data=%h",
                             resp_compute_id, resp_data, mon_resp[IW+DW-1:DW], mon_resp[DW-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((gq.size() != 0 || rq.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        vec_count++;
        if (gq.size() != 0 || rq.size() != 0 || busy !== 1'b0) begin
            err_count++;
            $display("FAIL %s_drain: got %0d grants and %0d responses pending busy=%b, required 0/0/0",
                     name, gq.size(), rq.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vec_count++;
        if ({grant, mem_addr_en, resp_en, busy, timeout_err} !== '0) begin
            err_count++;
            $display("FAIL reset_strobes: got grant=%b addr_en=%b resp_en=%b busy=%b terr=%b, required all 0",
                     grant, mem_addr_en, resp_en, busy, timeout_err);
        end
        vec_count++;
        if (mem_compute_id !== NO_ID || resp_compute_id !== NO_ID) begin
            err_count++;
            $display("FAIL reset_ids: got mem_id=%0d resp_id=%0d, required %0d/%0d", mem_compute_id, resp_compute_id, N, N);
        end
        vec_count++;
        if (mem_addr !== '0 || resp_data !== '0) begin
            err_count++;
            $display("FAIL reset_data: got addr=%h data=%h, required 0/0", mem_addr, resp_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        remaining[0] = 2;
        remaining[3] = 2;
        remaining[7] = 2;
        for (int r = 0; r < 2; r++) begin
            gq.push_back(0); rq.push_back(exp_resp(0));
            gq.push_back(3); rq.push_back(exp_resp(3));
            gq.push_back(7); rq.push_back(exp_resp(7));
        end
        wait_done("round_robin", 200);
    endtask

    task automatic test_single();
        remaining[5] = 1;
        gq.push_back(5);
        rq.push_back(exp_resp(5));
        step();
        vec_count++;
        if (grant !== 8'b0010_0000 || mem_addr_en !== 1'b1 || mem_compute_id !== IW'(5)) begin
            err_count++;
            $display("FAIL single_cycle1: got grant=%b en=%b id=%0d, required 00100000/1/5", grant, mem_addr_en, mem_compute_id);
        end
        step();
        vec_count++;
        if (grant !== '0 || mem_addr_en !== 1'b0 || busy !== 1'b1 || resp_en !== 1'b0) begin
            err_count++;
            $display("FAIL single_cycle2: got grant=%b en=%b busy=%b resp_en=%b, required 0/0/1/0", grant, mem_addr_en, busy, resp_en);
        end
        step();
        vec_count++;
        if (resp_en !== 1'b1 || resp_compute_id !== IW'(5) || resp_data !== mem_model(unit_addr[5])) begin
            err_count++;
            $display("FAIL single_cycle3: got resp_en=%b id=%0d data=%h, required 1/5/%h",
                     resp_en, resp_compute_id, resp_data, mem_model(unit_addr[5]));
        end
        step();
        vec_count++;
        if (busy !== 1'b0 || resp_en !== 1'b0 || resp_compute_id !== NO_ID || mem_compute_id !== NO_ID) begin
            err_count++;
            $display("FAIL single_cycle4: got busy=%b resp_en=%b resp_id=%0d mem_id=%0d, required 0/0/%0d/%0d",
                     busy, resp_en, resp_compute_id, mem_compute_id, N, N);
        end
        wait_done("single", 20);
    endtask

    task automatic test_wrap();
        // Serve unit 6 so the pointer sits at 7, then 2 and 5 together must wrap to 2 first.
        remaining[6] = 1;
        gq.push_back(6); rq.push_back(exp_resp(6));
        wait_done("wrap_setup", 20);
        remaining[2] = 1;
        remaining[5] = 1;
        gq.push_back(2); rq.push_back(exp_resp(2));
        gq.push_back(5); rq.push_back(exp_resp(5));
        wait_done("wrap", 40);
    endtask

    task automatic test_stall();
        ready_delay = 5;
        spurious    = 1'b1;
        remaining[4] = 1;
        gq.push_back(4); rq.push_back(exp_resp(4));
        for (int s = 1; s <= 6; s++) begin
            step();
            vec_count++;
            if (mem_addr_en !== 1'b1 || mem_compute_id !== IW'(4) || mem_addr !== unit_addr[4] || busy !== 1'b1) begin
                err_count++;
                $display("FAIL stall_issue%0d: got en=%b id=%0d addr=%h, required 1/4/%h",
                         s, mem_addr_en, mem_compute_id, mem_addr, unit_addr[4]);
            end
        end
        step();
        vec_count++;
        if (mem_addr_en !== 1'b0 || busy !== 1'b1 || resp_en !== 1'b0) begin
            err_count++;
            $display("FAIL stall_wait: got en=%b busy=%b resp_en=%b, required 0/1/0", mem_addr_en, busy, resp_en);
        end
        ready_delay = 0;
        spurious    = 1'b0;
        wait_done("stall", 20);
    endtask

    task automatic test_timeout();
        hold_data = 1'b1;
        remaining[1] = 1;
        gq.push_back(1);
        step();
        for (int s = 0; s < TO; s++) begin
            step();
            vec_count++;
            if (busy !== 1'b1 || mem_addr_en !== 1'b0 || resp_en !== 1'b0 || timeout_err !== 1'b0) begin
                err_count++;
                $display("FAIL timeout_wait%0d: got busy=%b en=%b resp_en=%b terr=%b, required 1/0/0/0",
                         s, busy, mem_addr_en, resp_en, timeout_err);
            end
        end
`ifdef FACTOR_ARB_TIMEOUT_EN
        step();
        vec_count++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || resp_en !== 1'b0) begin
            err_count++;
            $display("FAIL timeout_fire: got busy=%b terr=%b resp_en=%b, required 0/1/0", busy, timeout_err, resp_en);
        end
        pend      = 1'b0;
        hold_data = 1'b0;
        remaining[6] = 1;
        gq.push_back(6); rq.push_back(exp_resp(6));
        wait_done("timeout_after", 20);
        vec_count++;
        if (timeout_err !== 1'b1) begin
            err_count++;
            $display("FAIL timeout_sticky: got terr=%b, required 1", timeout_err);
        end
`else
        for (int s = 0; s < 24; s++) step();
        vec_count++;
        if (busy !== 1'b1 || timeout_err !== 1'b0 || mem_addr_en !== 1'b0) begin
            err_count++;
            $display("FAIL timeout_disabled: got busy=%b terr=%b en=%b, required 1/0/0", busy, timeout_err, mem_addr_en);
        end
        rq.push_back(exp_resp(1));
        hold_data = 1'b0;
        wait_done("timeout_release", 20);
`endif
    endtask

    task automatic test_reset_mid();
        hold_data = 1'b1;
        remaining[3] = 1;
        gq.push_back(3);
        step();
        step();
        vec_count++;
        if (busy !== 1'b1 || mem_addr_en !== 1'b0) begin
            err_count++;
            $display("FAIL rstmid_wait: got busy=%b en=%b, required 1/0", busy, mem_addr_en);
        end
        rst = 1'b1;
        #1;
        vec_count++;
        if ({grant, mem_addr_en, resp_en, busy, timeout_err} !== '0 ||
            mem_compute_id !== NO_ID || resp_compute_id !== NO_ID || mem_addr !== '0 || resp_data !== '0) begin
            err_count++;
            $display("FAIL rstmid_async: got busy=%b en=%b resp_en=%b terr=%b ids=%0d/%0d addr=%h data=%h, required idle values ids=%0d",
                     busy, mem_addr_en, resp_en, timeout_err, mem_compute_id, resp_compute_id, mem_addr, resp_data, N);
        end
        step();
        rst       = 1'b0;
        hold_data = 1'b0;
        step();
        step();
        vec_count++;
        if (busy !== 1'b0 || resp_en !== 1'b0 || resp_data !== '0) begin
            err_count++;
            $display("FAIL rstmid_stale: got busy=%b resp_en=%b data=%h, required 0/0/0", busy, resp_en, resp_data);
        end
        remaining[1] = 1;
        gq.push_back(1); rq.push_back(exp_resp(1));
        step();
        vec_count++;
        if (grant !== 8'b0000_0010 || mem_compute_id !== IW'(1)) begin
            err_count++;
            $display("FAIL rstmid_regrant: got grant=%b id=%0d, required 00000010/1", grant, mem_compute_id);
        end
        wait_done("rstmid", 20);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            unit_addr[k] = {16'(16'h1000 + k * 16'h0111), 16'(k * 16'h0037 + 16'h0005)};
            req_addr[k*AW +: AW] = unit_addr[k];
            remaining[k] = 0;
            outstanding[k] = 1'b0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "simulation time limit");
    end

endmodule
